ram_burst_master: RTL and testbench

- Synthesizable initiator that drives one port of the true dual-port RAM: registered we/addr/din out, dout in.
- Accepts commands over a valid/ready handshake: single write, single read, pattern-fill burst, read-back burst.
- Replaces testbench-style task sequencing with RTL so on-chip logic can initialise and read back RAM contents.
- Returns read data tagged with its address and signals command completion.

---
 rtl/ram_burst_master.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ram_burst_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// ram_burst_master: command-driven initiator for one port of a dual-port RAM.
// Accepts single/burst write and read commands, and returns read data tagged
// with its address.
// Optional build macro RAM_BURST_MASTER_CHECK_EN adds a read-back compare
// (chk_err / chk_cnt) for burst-read commands.

module ram_burst_master #(
  parameter int  DATA_WIDTH = 16,
  parameter int  DATA_DEPTH = 256,
  parameter int  RD_LAT     = 1,
  localparam int AW         = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [AW:0]           cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_step,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [AW-1:0]         rd_addr,
`ifdef RAM_BURST_MASTER_CHECK_EN
  output logic                  chk_err,
  output logic [AW:0]           chk_cnt,
`endif
  output logic                  done
);

  localparam logic [AW:0]   MAX_LEN      = (AW+1)'(DATA_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR    = AW'(DATA_DEPTH - 1);
  localparam logic [2:0]    DRAIN_CYCLES = 3'(RD_LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [AW:0]           remain_q, remain_d;
  logic [2:0]            drain_q, drain_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic                  ram_we_q, ram_we_d;
  logic [AW-1:0]         ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  rd_issue_q, rd_issue_d;

  logic [RD_LAT-1:0]          pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][AW-1:0]  pipe_addr_q, pipe_addr_d;

  logic                  accept;
  logic [AW:0]           eff_len;
  logic [AW-1:0]         next_addr;

`ifdef RAM_BURST_MASTER_CHECK_EN
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  chk_err_q, chk_err_d;
  logic [AW:0]           chk_cnt_q, chk_cnt_d;
`endif

  // Command acceptance, effective burst length and wrapping address increment.
  always_comb begin
    accept = cmd_valid && (state_q == ST_IDLE) && !rst;
    if (!cmd_op[1]) begin
      eff_len = (AW+1)'(1);
    end else if (cmd_len > MAX_LEN) begin
      eff_len = MAX_LEN;
    end else begin
      eff_len = cmd_len;
    end
    if (ram_addr_q == LAST_ADDR) begin
      next_addr = '0;
    end else begin
      next_addr = ram_addr_q + AW'(1);
    end
  end

  // State register plus all datapath flops; reset flushes the read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      drain_q     <= '0;
      step_q      <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rd_issue_q  <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_addr_q <= '0;
`ifdef RAM_BURST_MASTER_CHECK_EN
      op_q        <= '0;
      exp_q       <= '0;
      chk_err_q   <= 1'b0;
      chk_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      drain_q     <= drain_d;
      step_q      <= step_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rd_issue_q  <= rd_issue_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
`ifdef RAM_BURST_MASTER_CHECK_EN
      op_q        <= op_d;
      exp_q       <= exp_d;
      chk_err_q   <= chk_err_d;
      chk_cnt_q   <= chk_cnt_d;
`endif
    end
  end

  // Next-state logic: IDLE -> WR/RD (or DONE for empty bursts), RD -> DRAIN -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (eff_len == '0) begin
            state_d = ST_DONE;
          end else if (cmd_op[0]) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (remain_q <= (AW+1)'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_RD: begin
        if (remain_q <= (AW+1)'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q <= 3'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access generation: the first beat is loaded at acceptance so it appears the next cycle.
  always_comb begin
    remain_d   = remain_q;
    drain_d    = drain_q;
    step_d     = step_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rd_issue_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          step_d   = cmd_step;
          remain_d = eff_len;
          if (eff_len != '0) begin
            ram_addr_d = cmd_addr;
            if (cmd_op[0]) begin
              rd_issue_d = 1'b1;
            end else begin
              ram_we_d  = 1'b1;
              ram_din_d = cmd_data;
            end
          end
        end
      end
      ST_WR: begin
        if (remain_q > (AW+1)'(1)) begin
          remain_d   = remain_q - (AW+1)'(1);
          ram_addr_d = next_addr;
          ram_din_d  = ram_din_q + step_q;
          ram_we_d   = 1'b1;
        end else begin
          remain_d = '0;
        end
      end
      ST_RD: begin
        if (remain_q > (AW+1)'(1)) begin
          remain_d   = remain_q - (AW+1)'(1);
          ram_addr_d = next_addr;
          rd_issue_d = 1'b1;
        end else begin
          remain_d = '0;
          drain_d  = DRAIN_CYCLES;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 3'd1;
      end
      default: begin
        remain_d = remain_q;
      end
    endcase
  end

  // Read-return delay line: tags each issued read with its address for RD_LAT cycles.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_addr_d    = pipe_addr_q;
    pipe_vld_d[0]  = rd_issue_q;
    pipe_addr_d[0] = ram_addr_q;
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_addr_d[k] = pipe_addr_q[k-1];
    end
  end

`ifdef RAM_BURST_MASTER_CHECK_EN
  // Burst read-back compare against the seed/step sequence, cleared per burst-read command.
  always_comb begin
    op_d      = op_q;
    exp_d     = exp_q;
    chk_err_d = chk_err_q;
    chk_cnt_d = chk_cnt_q;
    if (accept) begin
      op_d = cmd_op;
      if (cmd_op == 2'b11) begin
        exp_d     = cmd_data;
        chk_err_d = 1'b0;
        chk_cnt_d = '0;
      end
    end else if (pipe_vld_q[RD_LAT-1] && (op_q == 2'b11)) begin
      exp_d = exp_q + step_q;
      if (ram_dout != exp_q) begin
        chk_err_d = 1'b1;
        if (chk_cnt_q != '1) begin
          chk_cnt_d = chk_cnt_q + (AW+1)'(1);
        end
      end
    end
  end

  assign chk_err = chk_err_q;
  assign chk_cnt = chk_cnt_q;
`endif

  // Output decode: handshake and completion pulse are suppressed while reset is held.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !rst;
    done      = (state_q == ST_DONE) && !rst;
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_din   = ram_din_q;
    rd_valid  = pipe_vld_q[RD_LAT-1];
    rd_addr   = pipe_addr_q[RD_LAT-1];
    rd_data   = pipe_vld_q[RD_LAT-1] ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: drives ram_burst_master against a behavioural RAM port.
// Expected accesses, read returns and done pulses are queued at command
// acceptance and consumed by a negedge monitor.

module tb_ram_burst_master;

  localparam int RD_LAT = 1;
  localparam int DEPTH  = 256;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [7:0]  cmdAddr;
  logic [8:0]  cmdLen;
  logic [15:0] cmdData;
  logic [15:0] cmdStep;
  logic        ramWe;
  logic [7:0]  ramAddr;
  logic [15:0] ramDin;
  logic [15:0] ramDout;
  logic        rdValid;
  logic [15:0] rdData;
  logic [7:0]  rdAddr;
  logic        done;
`ifdef RAM_BURST_MASTER_CHECK_EN
  logic        chkErr;
  logic [8:0]  chkCnt;
`endif

  ram_burst_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_op    (cmdOp),
    .cmd_addr  (cmdAddr),
    .cmd_len   (cmdLen),
    .cmd_data  (cmdData),
    .cmd_step  (cmdStep),
    .ram_we    (ramWe),
    .ram_addr  (ramAddr),
    .ram_din   (ramDin),
    .ram_dout  (ramDout),
    .rd_valid  (rdValid),
    .rd_data   (rdData),
    .rd_addr   (rdAddr),
`ifdef RAM_BURST_MASTER_CHECK_EN
    .chk_err   (chkErr),
    .chk_cnt   (chkCnt),
`endif
    .done      (done)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } expAcc_t;

  typedef struct {
    logic [1:0] op;
    int addr;
    int len;
    int data;
    int step;
    int expN;
    int expLat;
  } vec_t;

  expAcc_t wq[$];
  expAcc_t rq[$];
  int      dq[$];
  int      model [DEPTH];
  logic [15:0] ram [DEPTH];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  vec_t    vecs [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to timestamp every expected event
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM port, read-first, one cycle read latency
  always @(posedge clk) begin
    if (ramWe) ram[ramAddr] <= ramDin;
    ramDout <= ram[ramAddr];
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void pushExpect(input logic [1:0] op, input int addr, input int data,
                                     input int step, input int n, input int lat, input int acc);
    for (int i = 0; i < n; i++) begin
      int a;
      int d;
      a = (addr + i) % DEPTH;
      d = (data + i * step) & 16'hFFFF;
      if (op[0] == 1'b0) begin
        model[a] = d;
        wq.push_back('{acc + 1 + i, a, d});
      end else begin
        rq.push_back('{acc + 1 + i + RD_LAT, a, model[a]});
      end
    end
    if (lat >= 0) dq.push_back(acc + lat);
  endfunction

  // Scoreboard monitor: every write, read return and done pulse must match the queue head
  always @(negedge clk) begin : monitor
    expAcc_t e;
    if (ramWe) begin
      if (wq.size() == 0) checkOutput("wr_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        checkOutput("wr_cycle", cyc, e.cyc);
        checkOutput("wr_addr", ramAddr, e.addr);
        checkOutput("wr_data", ramDin, e.data);
      end
    end
    if (rdValid) begin
      if (rq.size() == 0) checkOutput("rd_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        checkOutput("rd_cycle", cyc, e.cyc);
        checkOutput("rd_addr", rdAddr, e.addr);
        checkOutput("rd_data", rdData, e.data);
      end
    end
    if (done) begin
      if (dq.size() == 0) checkOutput("done_unexpected", 1, 0);
      else checkOutput("done_cycle", cyc, dq.pop_front());
    end
  end

  // Called just after a rising edge; returns just after the edge following acceptance
  task automatic sendCmd(input logic [1:0] op, input int addr, input int len, input int data,
                         input int step, input int expN, input int expLat, input bit hold,
                         output int acc);
    bit got;
    cmdOp    = op;
    cmdAddr  = 8'(addr);
    cmdLen   = 9'(len);
    cmdData  = 16'(data);
    cmdStep  = 16'(step);
    cmdValid = 1'b1;
    got = 1'b0;
    acc = -1;
    for (int w = 0; w < 1000 && !got; w++) begin
      @(negedge clk);
      if (cmdReady) begin
        got = 1'b1;
        acc = cyc;
        pushExpect(op, addr, data, step, expN, expLat, acc);
      end
      @(posedge clk);
      #1;
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    if (!hold) cmdValid = 1'b0;
  endtask

  task automatic drainAll();
    bit empty;
    empty = 1'b0;
    for (int w = 0; w < 600 && !empty; w++) begin
      @(negedge clk);
      empty = (wq.size() == 0) && (rq.size() == 0) && (dq.size() == 0) && cmdReady;
      @(posedge clk);
      #1;
    end
    checkOutput("queues_empty", wq.size() + rq.size() + dq.size(), 0);
    wq.delete();
    rq.delete();
    dq.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    int acc;
    sendCmd(v.op, v.addr, v.len, v.data, v.step, v.expN, v.expLat, 1'b0, acc);
    drainAll();
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int accA;
    int accB;

    vecs[0]  = '{2'b10,   0,  10,   100,      1,  10,  11};
    vecs[1]  = '{2'b11,   0,  10,     0,      0,  10,  12};
    vecs[2]  = '{2'b10, 250,  10,     0,      3,  10,  11};
    vecs[3]  = '{2'b11, 250,  10,     0,      0,  10,  12};
    vecs[4]  = '{2'b00,   5,   7, 'hBEEF,     9,   1,   2};
    vecs[5]  = '{2'b01,   5,   0,     0,      0,   1,   3};
    vecs[6]  = '{2'b10,  40,   0,    55,      1,   0,   1};
    vecs[7]  = '{2'b11,  40,   0,     0,      0,   0,   1};
    vecs[8]  = '{2'b10,   0, 300,     7, 'h1111, 256, 257};
    vecs[9]  = '{2'b11,  17, 257,     0,      0, 256, 258};
    vecs[10] = '{2'b10, 100,   3, 'hFFFE,     1,   3,   4};
    vecs[11] = '{2'b11,  99,   5,     0,      0,   5,   7};

    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdOp    = 2'b00;
    cmdAddr  = '0;
    cmdLen   = '0;
    cmdData  = '0;
    cmdStep  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("ready_in_reset", cmdReady, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", cmdReady, 1);
    checkOutput("we_after_reset", ramWe, 0);
    checkOutput("addr_after_reset", ramAddr, 0);
    checkOutput("din_after_reset", ramDin, 0);
    checkOutput("rdvalid_after_reset", rdValid, 0);
    checkOutput("rddata_after_reset", rdData, 0);
    checkOutput("rdaddr_after_reset", rdAddr, 0);
    checkOutput("done_after_reset", done, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Command held while a long fill is busy: accepted the cycle after done
    sendCmd(2'b10, 30, 20, 500, 2, 20, 21, 1'b1, accA);
    sendCmd(2'b11, 30, 20, 0, 0, 20, 22, 1'b0, accB);
    checkOutput("b2b_accept_cycle", accB, accA + 22);
    drainAll();

    // Reset during the fifth beat of a burst read
    sendCmd(2'b11, 0, 10, 0, 0, 4, -1, 1'b0, accA);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_beat_cycle", cyc, accA + 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_ready", cmdReady, 1);
    checkOutput("rst_mid_we", ramWe, 0);
    checkOutput("rst_mid_rdvalid", rdValid, 0);
    checkOutput("rst_mid_done", done, 0);
    repeat (5) @(posedge clk);
    #1;
    drainAll();

`ifdef RAM_BURST_MASTER_CHECK_EN
    sendCmd(2'b10, 0, 10, 100, 1, 10, 11, 1'b0, accA);
    drainAll();
    sendCmd(2'b00, 3, 1, 0, 0, 1, 2, 1'b0, accA);
    drainAll();
    sendCmd(2'b11, 0, 10, 100, 1, 10, 12, 1'b0, accA);
    drainAll();
    @(negedge clk);
    checkOutput("chk_cnt_one", chkCnt, 1);
    checkOutput("chk_err_one", chkErr, 1);
    @(posedge clk);
    #1;
    sendCmd(2'b11, 0, 10, 101, 1, 10, 12, 1'b0, accA);
    @(negedge clk);
    checkOutput("chk_cnt_cleared", chkCnt, 0);
    checkOutput("chk_err_cleared", chkErr, 0);
    @(posedge clk);
    #1;
    drainAll();
    @(negedge clk);
    checkOutput("chk_cnt_ten", chkCnt, 10);
    checkOutput("chk_err_ten", chkErr, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
